// File: rtl/spi_cmd_regfile_if.sv
// Receive-side link between the SPI slave and the command register file.
// valid/ready: rx_valid is a level held while rx_word is complete; each rising
// edge of rx_valid is one frame, and frame_ack pulses once per accepted frame.
interface spi_cmd_regfile_if;
   logic [15:0] rx_word;
   logic        rx_valid;
   logic        frame_ack;

   modport master (
      output rx_word,
      output rx_valid,
      input  frame_ack
   );

   modport slave (
      input  rx_word,
      input  rx_valid,
      output frame_ack
   );
endinterface

// File: rtl/spi_cmd_regfile.sv
// SPI command decoder with shadow/active PWM duty and stepper angle registers,
// keyed atomic commit, and a link-loss watchdog that zeroes all duties.
module spi_cmd_regfile #(
   parameter int             NUM_CH     = 10,
   parameter int             DUTY_W     = 8,
   parameter int             ANG_W      = 12,
   parameter int             WDT_CYCLES = 50000000,
   parameter logic [7:0]     COMMIT_KEY = 8'hA5
) (
   input  logic                     clk50M,
   input  logic                     reset,
   spi_cmd_regfile_if.slave         rx,
   output logic [NUM_CH*DUTY_W-1:0] duty_flat,
   output logic [ANG_W-1:0]         angle_target,
   output logic                     cfg_valid,
   output logic                     wdt_tripped,
   output logic [7:0]               err_cnt
);

   localparam logic [3:0] ANGLE_ADDR = 4'd10;
   localparam logic [3:0] CTRL_ADDR  = 4'hF;
   localparam int         WDT_W      = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
   localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES - 1);

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_DUTY,
      CMD_ANGLE,
      CMD_COMMIT,
      CMD_ABORT,
      CMD_INVALID
   } cmd_e;

   logic              rx_valid_q;
   logic              cap_vld;
   logic [15:0]       cap_word;
   cmd_e              dec_cmd;
   logic [3:0]        dec_ch;
   logic [11:0]       dec_data;
   logic              frame_ack_q;
   logic              accept;
   logic [WDT_W-1:0]  wdt_cnt;

   logic [DUTY_W-1:0] shadow_duty [NUM_CH];
   logic [DUTY_W-1:0] active_duty [NUM_CH];
   logic [ANG_W-1:0]  shadow_angle;
   logic [ANG_W-1:0]  active_angle;

   function automatic cmd_e decode_word(input logic [15:0] w);
      cmd_e c;
      if (int'(w[15:12]) < NUM_CH)  c = CMD_DUTY;
      else if (w[15:12] == ANGLE_ADDR) c = CMD_ANGLE;
      else if (w[15:12] == CTRL_ADDR)  c = (w[7:0] == COMMIT_KEY) ? CMD_COMMIT : CMD_ABORT;
      else c = CMD_INVALID;
      return c;
   endfunction

   // Aborts count as accepted: they restart the watchdog and pulse frame_ack.
   assign accept = (dec_cmd == CMD_DUTY) || (dec_cmd == CMD_ANGLE) ||
                   (dec_cmd == CMD_COMMIT) || (dec_cmd == CMD_ABORT);

   always_ff @(posedge clk50M or posedge reset) begin
      if (reset) begin
         // History starts high so a word already present at release is ignored.
         rx_valid_q   <= 1'b1;
         cap_vld      <= 1'b0;
         cap_word     <= '0;
         dec_cmd      <= CMD_NONE;
         dec_ch       <= '0;
         dec_data     <= '0;
         frame_ack_q  <= 1'b0;
         wdt_cnt      <= '0;
         cfg_valid    <= 1'b0;
         wdt_tripped  <= 1'b0;
         err_cnt      <= '0;
         shadow_angle <= '0;
         active_angle <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_duty[i] <= '0;
            active_duty[i] <= '0;
         end
      end else begin
         rx_valid_q <= rx.rx_valid;
         cap_vld    <= rx.rx_valid & ~rx_valid_q;
         if (rx.rx_valid && !rx_valid_q) cap_word <= rx.rx_word;

         dec_cmd <= CMD_NONE;
         if (cap_vld) begin
            dec_cmd  <= decode_word(cap_word);
            dec_ch   <= cap_word[15:12];
            dec_data <= cap_word[11:0];
         end

         frame_ack_q <= accept;

         case (dec_cmd)
            CMD_DUTY: begin
               for (int i = 0; i < NUM_CH; i++)
                  if (dec_ch == 4'(i)) shadow_duty[i] <= dec_data[DUTY_W-1:0];
            end
            CMD_ANGLE: shadow_angle <= dec_data[ANG_W-1:0];
            CMD_COMMIT: begin
               for (int i = 0; i < NUM_CH; i++) active_duty[i] <= shadow_duty[i];
               active_angle <= shadow_angle;
               cfg_valid    <= 1'b1;
               wdt_tripped  <= 1'b0;
            end
            CMD_ABORT: begin
               for (int i = 0; i < NUM_CH; i++) shadow_duty[i] <= active_duty[i];
               shadow_angle <= active_angle;
            end
            CMD_INVALID: begin
               if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
            default: ;
         endcase

         // Expiry only acts without an accepted frame, so a same-cycle commit wins.
         if (accept) begin
            wdt_cnt <= '0;
         end else if (wdt_cnt == WDT_MAX) begin
            wdt_tripped <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) active_duty[i] <= '0;
         end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
         end
      end
   end

   assign rx.frame_ack = frame_ack_q;
   assign angle_target = active_angle;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
      assign duty_flat[g*DUTY_W +: DUTY_W] = active_duty[g];
   end

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Randomized self-checking bench for spi_cmd_regfile against a frame-level
// model of the shadow/active register bank, error counter and watchdog.
module tb_spi_cmd_regfile;

   localparam int NUM_CH = 10;
   localparam int WDT    = 1000;

   logic        clk;
   logic        reset;
   logic [79:0] duty_flat;
   logic [11:0] angle_target;
   logic        cfg_valid;
   logic        wdt_tripped;
   logic [7:0]  err_cnt;

   spi_cmd_regfile_if bus ();

   spi_cmd_regfile #(
      .NUM_CH    (NUM_CH),
      .DUTY_W    (8),
      .ANG_W     (12),
      .WDT_CYCLES(WDT),
      .COMMIT_KEY(8'hA5)
   ) dut (
      .clk50M      (clk),
      .reset       (reset),
      .rx          (bus.slave),
      .duty_flat   (duty_flat),
      .angle_target(angle_target),
      .cfg_valid   (cfg_valid),
      .wdt_tripped (wdt_tripped),
      .err_cnt     (err_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model
   logic [7:0]  m_sh [NUM_CH];
   logic [7:0]  m_act [NUM_CH];
   logic [11:0] m_sh_ang, m_act_ang;
   logic        m_cfg, m_trip;
   int          m_err;
   logic [15:0] exp_q[$];

   function automatic void model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_sh[i]  = 8'h00;
         m_act[i] = 8'h00;
      end
      m_sh_ang = '0; m_act_ang = '0;
      m_cfg = 1'b0; m_trip = 1'b0; m_err = 0;
      exp_q.delete();
   endfunction

   function automatic void model_frame(input logic [15:0] w);
      int addr;
      addr = int'(w[15:12]);
      if (addr < NUM_CH) begin
         m_sh[addr] = w[7:0];
         exp_q.push_back(w);
      end else if (addr == 10) begin
         m_sh_ang = w[11:0];
         exp_q.push_back(w);
      end else if (addr == 15) begin
         if (w[7:0] == 8'hA5) begin
            for (int i = 0; i < NUM_CH; i++) m_act[i] = m_sh[i];
            m_act_ang = m_sh_ang;
            m_cfg = 1'b1;
            m_trip = 1'b0;
         end else begin
            for (int i = 0; i < NUM_CH; i++) m_sh[i] = m_act[i];
            m_sh_ang = m_act_ang;
         end
         exp_q.push_back(w);
      end else begin
         m_err = (m_err >= 255) ? 255 : m_err + 1;
      end
   endfunction

   function automatic void model_trip();
      m_trip = 1'b1;
      for (int i = 0; i < NUM_CH; i++) m_act[i] = 8'h00;
   endfunction

   function automatic logic [79:0] exp_flat();
      logic [79:0] f;
      f = '0;
      for (int i = 0; i < NUM_CH; i++) f[i*8 +: 8] = m_act[i];
      return f;
   endfunction

   // scoreboard: every observed frame_ack must retire one expected frame
   always @(negedge clk) begin
      if (bus.frame_ack === 1'b1) begin
         if (exp_q.size() == 0) check("unexpected_ack", 1'b1, 1'b0);
         else void'(exp_q.pop_front());
      end
   end

   task automatic check_state(input string tag);
      check({tag, "_duty"},  duty_flat,    exp_flat());
      check({tag, "_angle"}, angle_target, m_act_ang);
      check({tag, "_cfg"},   cfg_valid,    m_cfg);
      check({tag, "_trip"},  wdt_tripped,  m_trip);
      check({tag, "_err"},   err_cnt,      m_err);
      check({tag, "_acks_pending"}, exp_q.size(), 0);
   endtask

   // drivers
   task automatic send_frame(input logic [15:0] w);
      @(negedge clk);
      bus.rx_word  = w;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      model_frame(w);
      repeat (3) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [15:0] w;
      logic [11:0] ang_before;
      reset        = 1'b1;
      bus.rx_word  = 16'h0000;
      bus.rx_valid = 1'b0;
      model_reset();
      idle(3);
      check_state("reset");
      reset = 1'b0;
      idle(2);

      // shadow writes stay invisible until a commit; commit lands at k+2
      send_frame(16'h3080);
      send_frame(16'hA5DC);
      check_state("pre_commit");
      @(negedge clk);
      bus.rx_word  = 16'hF0A5;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      @(negedge clk);
      check("lat_k1_cfg", cfg_valid, 1'b0);
      @(negedge clk);
      check("lat_k2_cfg", cfg_valid, 1'b1);
      check("lat_k2_ch3", duty_flat[31:24], 8'h80);
      check("lat_k2_angle", angle_target, 12'h5DC);
      model_frame(16'hF0A5);
      idle(2);
      check_state("commit1");

      // a held rx_valid is one frame only
      @(negedge clk);
      bus.rx_word  = 16'h0140;
      bus.rx_valid = 1'b1;
      model_frame(16'h0140);
      idle(100);
      bus.rx_valid = 1'b0;
      idle(3);
      check_state("hold");
      send_frame(16'hF0A5);
      check("hold_ch0", duty_flat[7:0], 8'h40);
      check_state("hold_commit");

      // invalid frames saturate err_cnt and never ack
      send_frame(16'h0240);
      for (int i = 0; i < 260; i++) begin
         @(negedge clk);
         bus.rx_word  = 16'hC000 | 16'($urandom_range(0, 4095));
         bus.rx_valid = 1'b1;
         @(negedge clk);
         bus.rx_valid = 1'b0;
         model_frame(bus.rx_word);
      end
      idle(3);
      check("err_sat", err_cnt, 8'hFF);
      check_state("err");

      // abort discards the pending ch5 write
      send_frame(16'h5033);
      send_frame(16'hF000);
      send_frame(16'hF0A5);
      check("abort_ch5", duty_flat[47:40], 8'h00);
      check_state("abort");

      // randomized frames
      for (int n = 0; n < 40; n++) begin
         w[15:12] = 4'($urandom_range(0, 15));
         w[11:0]  = 12'($urandom_range(0, 4095));
         if (w[15:12] == 4'hF && $urandom_range(0, 1) == 1) w[7:0] = 8'hA5;
         send_frame(w);
         check_state("rand");
         idle($urandom_range(0, 3));
      end

      // watchdog: trips after WDT idle cycles, only a commit restores duties
      send_frame(16'h90FF);
      send_frame(16'hF0A5);
      ang_before = m_act_ang;
      check("wdt_ch9_set", duty_flat[79:72], 8'hFF);
      idle(900);
      check("wdt_not_yet", wdt_tripped, 1'b0);
      idle(110);
      model_trip();
      check("wdt_tripped", wdt_tripped, 1'b1);
      check("wdt_duty_zero", duty_flat, 80'h0);
      check("wdt_angle_held", angle_target, ang_before);
      send_frame(16'h9011);
      check("wdt_write_stays_zero", duty_flat, 80'h0);
      check_state("wdt_write");
      send_frame(16'h90FF);
      send_frame(16'hF0A5);
      check("wdt_restore_ch9", duty_flat[79:72], 8'hFF);
      check_state("wdt_restore");

      // reset between capture and decode of a commit; word held across release
      send_frame(16'h2077);
      @(negedge clk);
      bus.rx_word  = 16'hF0A5;
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      model_reset();
      check("rst_async_duty", duty_flat, 80'h0);
      check("rst_async_cfg", cfg_valid, 1'b0);
      check("rst_async_angle", angle_target, 12'h0);
      idle(3);
      reset = 1'b0;
      idle(6);
      check_state("rst_release");
      bus.rx_valid = 1'b0;
      send_frame(16'hF0A5);
      check_state("rst_fresh_commit");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_cmd_regfile.md
Name: spi_cmd_regfile

Overview:
- Command decoder and register bank directly downstream of the SPI slave.
- Consumes each received 16-bit word and writes it into shadow registers for the PWM duty channels and the stepper target angle.
- Transfers all shadow values to the active outputs atomically on a keyed commit frame.
- Provides a link-loss watchdog that forces all PWM duties to zero when the SPI master goes silent.

Parameters:
- NUM_CH, 10, number of PWM duty channels; channel 9 is the vent channel.
- DUTY_W, 8, width of each duty value.
- ANG_W, 12, width of the stepper target angle.
- WDT_CYCLES, 50000000, number of clk50M cycles without an accepted frame before the watchdog trips (1 s).
- COMMIT_KEY, 8'hA5, data byte required in a commit frame.

Ports:
- clk50M  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- rx_word  input  16  received word from the SPI slave; stable while rx_valid is high.
- rx_valid  input  1  level, high while rx_word holds a complete word; already synchronous to clk50M.
- duty_flat  output  NUM_CH*DUTY_W  active duties; channel i occupies bits [i*DUTY_W +: DUTY_W].
- angle_target  output  ANG_W  active stepper target angle.
- cfg_valid  output  1  high once the first commit has completed.
- wdt_tripped  output  1  watchdog has expired; duties are forced to zero.
- err_cnt  output  8  count of rejected frames, saturating.
- frame_ack  output  1  one-cycle pulse for each accepted frame.

Behaviour:
- Reset (asynchronous):
  - All shadow and active registers go to 0.
  - cfg_valid=0, wdt_tripped=0, err_cnt=0, frame_ack=0.
  - Watchdog counter and dirty flags go to 0.
  - The rx_valid history register goes to 1, so a word already present when reset is released is not consumed.
- Frame detection:
  - A frame is the rising edge of rx_valid, i.e. rx_valid=1 this cycle with the registered value 0.
  - rx_word is captured on the same clock edge. Exactly one frame is consumed per rising edge; holding rx_valid high does not repeat it.
- Decode is registered and takes one cycle after capture. The frame format is addr=rx_word[15:12].
  - addr 0..NUM_CH-1: shadow_duty[addr] <= rx_word[7:0]. Bits [11:8] are ignored. Set dirty.
  - addr 10: shadow_angle <= rx_word[11:0]. Set dirty.
  - addr 15 with rx_word[7:0]==COMMIT_KEY (commit):
    - active <= shadow for all channels and the angle, simultaneously.
    - cfg_valid <= 1, wdt_tripped <= 0, dirty cleared.
  - addr 15 with any other data (abort): shadow <= active, dirty cleared, no output change. This counts as accepted.
  - addr 11..14 (invalid): no register change; err_cnt increments, saturating at 255. frame_ack stays low. The watchdog is not restarted.
- Latency:
  - With the rising edge sampled at clock k, the decoded effect and the frame_ack pulse appear at clock k+2.
  - On a commit, duty_flat and angle_target change at k+2.
- Watchdog:
  - The counter clears on every accepted frame (frame_ack) and otherwise increments, saturating.
  - When it reaches WDT_CYCLES-1: wdt_tripped <= 1 and all active duties <= 0. angle_target and the shadows are held.
  - While tripped, duties stay 0 even if shadows are written. Only a commit restores them.
  - If watchdog expiry and a commit land in the same cycle, the commit wins: outputs take shadow values, wdt_tripped=0, counter=0.
- A write to a shadow in the same cycle as a commit is not possible, since frames are serialised at one per edge.
- Reset asserted mid-frame discards any captured word. After reset deasserts, a frame needs a fresh rising edge of rx_valid.
- duty_flat, angle_target and the status outputs are driven directly from flops and are glitch-free.

Test Plan:
- Reset, then write addr 3 data 0x80 and addr 10 data 0x5DC: duty_flat and angle_target stay 0 and cfg_valid=0. Then send commit 0xF0A5: at k+2, duty ch3=0x80, angle_target=0x5DC, cfg_valid=1, one frame_ack per frame.
- Hold rx_valid high for 100 cycles with word 0x0140: ch0 shadow is written once and frame_ack pulses exactly once.
- Send addr 12 frames 260 times: err_cnt saturates at 255 with no register change; frame_ack is never seen.
- Write ch5=0x33, then send abort 0xF000, then commit: ch5 keeps its pre-abort active value.
- WDT_CYCLES=1000, after commit with ch9=0xFF, idle 1000 cycles:
  - wdt_tripped=1 and all duties=0; angle_target is unchanged.
  - Sending a commit restores ch9=0xFF and clears wdt_tripped.
- Assert reset asynchronously between the capture edge and the decode edge of a commit: all outputs go to 0 immediately, and no commit takes effect after release.
